// File: rtl/sal_sched_pkg.sv
// rtl/sal_sched_pkg.sv - shared types, widths and round-robin helper for the bank scheduler
package sal_sched_pkg;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ACT = 3'd1,
        RD  = 3'd2,
        WR  = 3'd3,
        PRE = 3'd4,
        REF = 3'd5
    } cmd_t;

    localparam int FAW_SLOTS     = 4;
    localparam int MAX_BANKS     = 16;

    localparam int T_RRD_WIDTH   = 4;
    localparam int T_CCD_WIDTH   = 4;
    localparam int T_WTR_WIDTH   = 4;
    localparam int T_RTW_WIDTH   = 4;

    localparam int DRAM_RA_WIDTH = 16;
    localparam int DRAM_CA_WIDTH = 10;
    localparam int AXI_ID_WIDTH  = 4;
    localparam int AXI_LEN_WIDTH = 8;

    // First set bit of req scanning upward from ptr, modulo (mask+1) banks.
    // Returns {found, idx}; req bits above the bank count must be zero.
    function automatic logic [4:0] rr_pick(input logic [MAX_BANKS-1:0] req,
                                           input logic [3:0] ptr,
                                           input logic [3:0] mask);
        logic       found;
        logic [3:0] idx;
        logic [3:0] cand;
        found = 1'b0;
        idx   = 4'd0;
        for (int k = 0; k < MAX_BANKS; k++) begin
            cand = (ptr + k[3:0]) & mask;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/sal_rr_picker.sv
// rtl/sal_rr_picker.sv - combinational round-robin picker for one command class
module sal_rr_picker
    import sal_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    logic [MAX_BANKS-1:0] req_pad;
    logic [4:0]           pick;

    // Widen to the helper's fixed width, pick, and expand the index to one-hot.
    always_comb begin
        req_pad        = '0;
        req_pad[N-1:0] = req;
        pick           = rr_pick(req_pad, 4'(ptr), 4'(N - 1));
        idx            = pick[$clog2(N)-1:0];
        gnt            = '0;
        if (pick[4]) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sal_multi_bank_sched.sv
// rtl/sal_multi_bank_sched.sv - per-cycle multi-bank DRAM command arbiter with inter-bank timing
module sal_multi_bank_sched
    import sal_sched_pkg::*;
#(
    parameter int NUM_BANKS   = 4,
    parameter int BA_WIDTH    = $clog2(NUM_BANKS),
    parameter bit FAW_EN      = 1'b1,
    parameter int T_FAW_WIDTH = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [T_RRD_WIDTH-1:0]             t_rrd_m1,
    input  logic [T_CCD_WIDTH-1:0]             t_ccd_m1,
    input  logic [T_WTR_WIDTH-1:0]             t_wtr_m1,
    input  logic [T_RTW_WIDTH-1:0]             t_rtw_m1,
    input  logic [T_FAW_WIDTH-1:0]             t_faw_m1,
    input  logic [NUM_BANKS-1:0]               act_req,
    input  logic [NUM_BANKS-1:0]               rd_req,
    input  logic [NUM_BANKS-1:0]               wr_req,
    input  logic [NUM_BANKS-1:0]               pre_req,
    input  logic [NUM_BANKS-1:0]               ref_req,
    input  logic [NUM_BANKS*DRAM_RA_WIDTH-1:0] ra_i,
    input  logic [NUM_BANKS*DRAM_CA_WIDTH-1:0] ca_i,
    input  logic [NUM_BANKS*AXI_ID_WIDTH-1:0]  id_i,
    input  logic [NUM_BANKS*AXI_LEN_WIDTH-1:0] len_i,
    output logic [NUM_BANKS-1:0]               act_gnt,
    output logic [NUM_BANKS-1:0]               rd_gnt,
    output logic [NUM_BANKS-1:0]               wr_gnt,
    output logic [NUM_BANKS-1:0]               pre_gnt,
    output logic [NUM_BANKS-1:0]               ref_gnt,
    output logic                               cmd_valid,
    output cmd_t                               cmd_type,
    output logic [BA_WIDTH-1:0]                cmd_ba,
    output logic [DRAM_RA_WIDTH-1:0]           cmd_ra,
    output logic [DRAM_CA_WIDTH-1:0]           cmd_ca,
    output logic [AXI_ID_WIDTH-1:0]            cmd_id,
    output logic [AXI_LEN_WIDTH-1:0]           cmd_len
);

    logic [T_RRD_WIDTH-1:0] rrd_cnt;
    logic [T_CCD_WIDTH-1:0] ccd_cnt;
    logic [T_WTR_WIDTH-1:0] wtr_cnt;
    logic [T_RTW_WIDTH-1:0] rtw_cnt;
    logic [BA_WIDTH-1:0]    rr_ptr;
    logic                   faw_ok;

    logic [NUM_BANKS-1:0] ref_sel, rd_sel, wr_sel, act_sel, pre_sel;
    logic [NUM_BANKS-1:0] ref_m, rw_m, act_m, pre_m;
    logic [NUM_BANKS-1:0] ref_pg, rw_pg, act_pg, pre_pg;
    logic [BA_WIDTH-1:0]  ref_idx, rw_idx, act_idx, pre_idx;
    logic                 act_ok, rd_ok, wr_ok, ref_ok;

    cmd_t                 win_type;
    logic [BA_WIDTH-1:0]  win_idx;

    // Each bank competes only in its own highest class; RD is taken over WR within one bank.
    assign ref_sel = ref_req;
    assign rd_sel  = rd_req  & ~ref_req;
    assign wr_sel  = wr_req  & ~ref_req & ~rd_req;
    assign act_sel = act_req & ~ref_req & ~rd_req & ~wr_req;
    assign pre_sel = pre_req & ~ref_req & ~rd_req & ~wr_req & ~act_req;

    assign act_ok = (rrd_cnt == '0) && faw_ok;
    assign rd_ok  = (ccd_cnt == '0) && (wtr_cnt == '0);
    assign wr_ok  = (ccd_cnt == '0) && (rtw_cnt == '0);
    assign ref_ok = (rrd_cnt == '0) && (ccd_cnt == '0);

    assign ref_m = ref_sel & {NUM_BANKS{ref_ok}};
    assign rw_m  = (rd_sel & {NUM_BANKS{rd_ok}}) | (wr_sel & {NUM_BANKS{wr_ok}});
    assign act_m = act_sel & {NUM_BANKS{act_ok}};
    assign pre_m = pre_sel;

    sal_rr_picker #(.N(NUM_BANKS)) u_pick_ref (.req(ref_m), .ptr(rr_ptr), .gnt(ref_pg), .idx(ref_idx));
    sal_rr_picker #(.N(NUM_BANKS)) u_pick_rw  (.req(rw_m),  .ptr(rr_ptr), .gnt(rw_pg),  .idx(rw_idx));
    sal_rr_picker #(.N(NUM_BANKS)) u_pick_act (.req(act_m), .ptr(rr_ptr), .gnt(act_pg), .idx(act_idx));
    sal_rr_picker #(.N(NUM_BANKS)) u_pick_pre (.req(pre_m), .ptr(rr_ptr), .gnt(pre_pg), .idx(pre_idx));

    // Fixed class priority over the masked requests; nothing is granted while in reset.
    always_comb begin
        act_gnt  = '0;
        rd_gnt   = '0;
        wr_gnt   = '0;
        pre_gnt  = '0;
        ref_gnt  = '0;
        win_type = NOP;
        win_idx  = '0;
        if (rst_n) begin
            if (|ref_m) begin
                ref_gnt  = ref_pg;
                win_type = REF;
                win_idx  = ref_idx;
            end else if (|rw_m) begin
                win_idx = rw_idx;
                if (rd_sel[rw_idx]) begin
                    rd_gnt   = rw_pg;
                    win_type = RD;
                end else begin
                    wr_gnt   = rw_pg;
                    win_type = WR;
                end
            end else if (|act_m) begin
                act_gnt  = act_pg;
                win_type = ACT;
                win_idx  = act_idx;
            end else if (|pre_m) begin
                pre_gnt  = pre_pg;
                win_type = PRE;
                win_idx  = pre_idx;
            end
        end
    end

    // Timing counters load on the grant edge and otherwise count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_cnt <= '0;
            ccd_cnt <= '0;
            wtr_cnt <= '0;
            rtw_cnt <= '0;
            rr_ptr  <= '0;
        end else begin
            if (win_type == ACT)                      rrd_cnt <= t_rrd_m1;
            else if (rrd_cnt != '0)                   rrd_cnt <= rrd_cnt - 1'b1;
            if (win_type == RD || win_type == WR)     ccd_cnt <= t_ccd_m1;
            else if (ccd_cnt != '0)                   ccd_cnt <= ccd_cnt - 1'b1;
            if (win_type == WR)                       wtr_cnt <= t_wtr_m1;
            else if (wtr_cnt != '0)                   wtr_cnt <= wtr_cnt - 1'b1;
            if (win_type == RD)                       rtw_cnt <= t_rtw_m1;
            else if (rtw_cnt != '0)                   rtw_cnt <= rtw_cnt - 1'b1;
            if (win_type != NOP)                      rr_ptr  <= win_idx + BA_WIDTH'(1);
        end
    end

    generate
        if (FAW_EN) begin : g_faw
            logic [T_FAW_WIDTH-1:0] faw_slot [FAW_SLOTS];
            logic [FAW_SLOTS-1:0]   slot_load;
            logic                   taken;

            // An ACT claims the lowest-index idle slot.
            always_comb begin
                slot_load = '0;
                taken     = 1'b0;
                for (int i = 0; i < FAW_SLOTS; i++) begin
                    if (win_type == ACT && !taken && faw_slot[i] == '0) begin
                        slot_load[i] = 1'b1;
                        taken        = 1'b1;
                    end
                end
            end

            // Slot countdown; ACT is allowed while any slot has expired.
            always_ff @(posedge clk or negedge rst_n) begin
                for (int i = 0; i < FAW_SLOTS; i++) begin
                    if (!rst_n)                  faw_slot[i] <= '0;
                    else if (slot_load[i])       faw_slot[i] <= t_faw_m1;
                    else if (faw_slot[i] != '0)  faw_slot[i] <= faw_slot[i] - 1'b1;
                end
            end

            assign faw_ok = (faw_slot[0] == '0) || (faw_slot[1] == '0) ||
                            (faw_slot[2] == '0) || (faw_slot[3] == '0);
        end else begin : g_no_faw
            assign faw_ok = 1'b1;
        end
    endgenerate

    // Registered command to the DFI side, one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_type  <= NOP;
            cmd_ba    <= '0;
            cmd_ra    <= '0;
            cmd_ca    <= '0;
            cmd_id    <= '0;
            cmd_len   <= '0;
        end else begin
            cmd_valid <= (win_type != NOP);
            cmd_type  <= win_type;
            if (win_type != NOP) begin
                cmd_ba  <= win_idx;
                cmd_ra  <= ra_i[win_idx*DRAM_RA_WIDTH +: DRAM_RA_WIDTH];
                cmd_ca  <= ca_i[win_idx*DRAM_CA_WIDTH +: DRAM_CA_WIDTH];
                cmd_id  <= id_i[win_idx*AXI_ID_WIDTH +: AXI_ID_WIDTH];
                cmd_len <= len_i[win_idx*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_sal_multi_bank_sched.sv
// tb/tb_sal_multi_bank_sched.sv - directed self-checking bench for sal_multi_bank_sched
module tb_sal_multi_bank_sched;
    import sal_sched_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
    logic [4:0]  t_faw_m1;
    logic [3:0]  act_req, rd_req, wr_req, pre_req, ref_req;
    logic [63:0] ra_i;
    logic [39:0] ca_i;
    logic [15:0] id_i;
    logic [31:0] len_i;

    logic [3:0]  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic        cmd_valid;
    cmd_t        cmd_type;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_ra;
    logic [9:0]  cmd_ca;
    logic [3:0]  cmd_id;
    logic [7:0]  cmd_len;

    logic [3:0]  act_gnt_nf, rd_gnt_nf, wr_gnt_nf, pre_gnt_nf, ref_gnt_nf;
    logic        cmd_valid_nf;
    cmd_t        cmd_type_nf;
    logic [1:0]  cmd_ba_nf;
    logic [15:0] cmd_ra_nf;
    logic [9:0]  cmd_ca_nf;
    logic [3:0]  cmd_id_nf;
    logic [7:0]  cmd_len_nf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] act_h [64];
    logic [3:0] rd_h  [64];
    logic [3:0] wr_h  [64];
    logic [3:0] pre_h [64];
    logic [3:0] ref_h [64];
    logic [3:0] act_nf_h [64];

    sal_multi_bank_sched #(.NUM_BANKS(4), .FAW_EN(1'b1), .T_FAW_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1), .t_faw_m1(t_faw_m1),
        .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
        .ra_i(ra_i), .ca_i(ca_i), .id_i(id_i), .len_i(len_i),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_ra(cmd_ra),
        .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len)
    );

    sal_multi_bank_sched #(.NUM_BANKS(4), .FAW_EN(1'b0), .T_FAW_WIDTH(5)) dut_nf (
        .clk(clk), .rst_n(rst_n),
        .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1), .t_faw_m1(t_faw_m1),
        .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
        .ra_i(ra_i), .ca_i(ca_i), .id_i(id_i), .len_i(len_i),
        .act_gnt(act_gnt_nf), .rd_gnt(rd_gnt_nf), .wr_gnt(wr_gnt_nf), .pre_gnt(pre_gnt_nf), .ref_gnt(ref_gnt_nf),
        .cmd_valid(cmd_valid_nf), .cmd_type(cmd_type_nf), .cmd_ba(cmd_ba_nf), .cmd_ra(cmd_ra_nf),
        .cmd_ca(cmd_ca_nf), .cmd_id(cmd_id_nf), .cmd_len(cmd_len_nf)
    );

    task automatic clear_reqs();
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    endtask

    // One-cycle reset pulse; returns just after a rising edge with reset released.
    task automatic pulse_reset();
        clear_reqs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Runs n cycles from posedge+1, logging grants; unless hold, a granted request drops next cycle.
    task automatic run(input int n, input bit hold);
        for (int c = 0; c < n; c++) begin
            #1;
            act_h[c] = act_gnt; rd_h[c] = rd_gnt; wr_h[c] = wr_gnt;
            pre_h[c] = pre_gnt; ref_h[c] = ref_gnt; act_nf_h[c] = act_gnt_nf;
            @(posedge clk); #1;
            if (!hold) begin
                act_req &= ~act_h[c]; rd_req &= ~rd_h[c]; wr_req &= ~wr_h[c];
                pre_req &= ~pre_h[c]; ref_req &= ~ref_h[c];
            end
        end
    endtask

    // cls: 0 act, 1 rd, 2 wr, 3 pre, 4 ref. Returns first logged cycle granting bank b, or -1.
    function automatic int first_gnt(input int cls, input int b, input int n);
        logic [3:0] v;
        for (int c = 0; c < n; c++) begin
            case (cls)
                0:       v = act_h[c];
                1:       v = rd_h[c];
                2:       v = wr_h[c];
                3:       v = pre_h[c];
                default: v = ref_h[c];
            endcase
            if (v[b]) return c;
        end
        return -1;
    endfunction

    task automatic test_reset();
        ref_req = 4'hF;
        #1;
        n_checks++; if (ref_gnt !== 4'h0) begin n_fail++; $display("FAIL reset_gnt: got %0h want 0", ref_gnt); end
        n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", cmd_valid); end
        n_checks++; if (cmd_type !== NOP) begin n_fail++; $display("FAIL reset_type: got %0d want 0", cmd_type); end
        n_checks++; if ({cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len} !== '0) begin n_fail++; $display("FAIL reset_fields: got nonzero want 0"); end
        clear_reqs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        t_rrd_m1 = 4'd15;
        act_req = 4'h1;
        run(1, 1'b0);
        n_checks++; if (act_h[0] !== 4'h1) begin n_fail++; $display("FAIL reset_first_act: got %0h want 1", act_h[0]); end
        n_checks++; if (cmd_valid !== 1'b1 || cmd_type !== ACT) begin n_fail++; $display("FAIL reset_act_cmd: got v=%0b t=%0d want v=1 t=1", cmd_valid, cmd_type); end
        act_req = 4'h2;
        #1;
        n_checks++; if (act_gnt !== 4'h0) begin n_fail++; $display("FAIL reset_rrd_block: got %0h want 0", act_gnt); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (act_gnt !== 4'h0 || cmd_valid !== 1'b0 || cmd_type !== NOP || cmd_ba !== 2'd0) begin
            n_fail++; $display("FAIL reset_mid: got gnt=%0h v=%0b t=%0d ba=%0d want all 0", act_gnt, cmd_valid, cmd_type, cmd_ba); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (act_gnt !== 4'h2) begin n_fail++; $display("FAIL reset_release_act: got %0h want 2", act_gnt); end
        @(posedge clk); #1;
        n_checks++; if (cmd_valid !== 1'b1 || cmd_ba !== 2'd1) begin n_fail++; $display("FAIL reset_release_cmd: got v=%0b ba=%0d want v=1 ba=1", cmd_valid, cmd_ba); end
        clear_reqs();
        t_rrd_m1 = 4'd0;
    endtask

    task automatic test_rr_fairness();
        logic [3:0] exp_seq [5];
        exp_seq[0] = 4'h1; exp_seq[1] = 4'h2; exp_seq[2] = 4'h4; exp_seq[3] = 4'h8; exp_seq[4] = 4'h1;
        t_rrd_m1 = 4'd0; t_faw_m1 = 5'd0;
        pulse_reset();
        act_req = 4'hF;
        run(5, 1'b1);
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (act_nf_h[c] !== exp_seq[c]) begin n_fail++; $display("FAIL rr_nofaw_c%0d: got %0h want %0h", c, act_nf_h[c], exp_seq[c]); end
            n_checks++; if (act_h[c] !== exp_seq[c]) begin n_fail++; $display("FAIL rr_faw0_c%0d: got %0h want %0h", c, act_h[c], exp_seq[c]); end
        end
        n_checks++; if (cmd_valid_nf !== 1'b1 || cmd_ba_nf !== 2'd0) begin n_fail++; $display("FAIL rr_cmd: got v=%0b ba=%0d want v=1 ba=0", cmd_valid_nf, cmd_ba_nf); end
        clear_reqs();
    endtask

    task automatic test_trrd();
        t_rrd_m1 = 4'd3;
        pulse_reset();
        act_req = 4'h3; pre_req = 4'h4;
        run(8, 1'b0);
        n_checks++; if (first_gnt(0, 0, 8) != 0) begin n_fail++; $display("FAIL trrd_act0: got %0d want 0", first_gnt(0, 0, 8)); end
        n_checks++; if (first_gnt(3, 2, 8) != 1) begin n_fail++; $display("FAIL trrd_pre2: got %0d want 1", first_gnt(3, 2, 8)); end
        n_checks++; if (first_gnt(0, 1, 8) != 4) begin n_fail++; $display("FAIL trrd_act1: got %0d want 4", first_gnt(0, 1, 8)); end
        clear_reqs();
        t_rrd_m1 = 4'd0;
    endtask

    task automatic test_tfaw();
        int got [5];
        int k;
        int exp_c [5];
        exp_c[0] = 0; exp_c[1] = 2; exp_c[2] = 4; exp_c[3] = 6; exp_c[4] = 16;
        t_rrd_m1 = 4'd1; t_faw_m1 = 5'd15;
        pulse_reset();
        act_req = 4'hF;
        run(20, 1'b1);
        k = 0;
        for (int i = 0; i < 5; i++) got[i] = -1;
        for (int c = 0; c < 20; c++) begin
            if (act_h[c] != 4'h0 && k < 5) begin got[k] = c; k++; end
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (got[i] != exp_c[i]) begin n_fail++; $display("FAIL tfaw_act%0d: got cycle %0d want %0d", i, got[i], exp_c[i]); end
        end
        n_checks++; if (act_h[16] !== 4'h1) begin n_fail++; $display("FAIL tfaw_fifth_bank: got %0h want 1", act_h[16]); end
        clear_reqs();
        t_rrd_m1 = 4'd0; t_faw_m1 = 5'd0;
    endtask

    task automatic test_turnaround();
        t_ccd_m1 = 4'd1; t_wtr_m1 = 4'd5; t_rtw_m1 = 4'd0;
        pulse_reset();
        wr_req = 4'h1; rd_req = 4'h2;
        run(10, 1'b0);
        n_checks++; if (first_gnt(2, 0, 10) != 0) begin n_fail++; $display("FAIL wtr_wr0: got %0d want 0", first_gnt(2, 0, 10)); end
        n_checks++; if (first_gnt(1, 1, 10) != 6) begin n_fail++; $display("FAIL wtr_rd1: got %0d want 6", first_gnt(1, 1, 10)); end
        pulse_reset();
        wr_req = 4'h5;
        run(6, 1'b0);
        n_checks++; if (first_gnt(2, 2, 6) != 2) begin n_fail++; $display("FAIL ccd_wr2: got %0d want 2", first_gnt(2, 2, 6)); end
        t_rtw_m1 = 4'd2;
        pulse_reset();
        rd_req = 4'h1; wr_req = 4'h2;
        run(6, 1'b0);
        n_checks++; if (first_gnt(1, 0, 6) != 0) begin n_fail++; $display("FAIL rtw_rd0: got %0d want 0", first_gnt(1, 0, 6)); end
        n_checks++; if (first_gnt(2, 1, 6) != 3) begin n_fail++; $display("FAIL rtw_wr1: got %0d want 3", first_gnt(2, 1, 6)); end
        clear_reqs();
        t_ccd_m1 = 4'd0; t_wtr_m1 = 4'd0; t_rtw_m1 = 4'd0;
    endtask

    task automatic test_priority();
        t_ccd_m1 = 4'd3;
        pulse_reset();
        ref_req = 4'h8; rd_req = 4'h1; act_req = 4'h2;
        #1;
        n_checks++; if ({ref_gnt, rd_gnt, wr_gnt, act_gnt, pre_gnt} !== {4'h8, 16'h0}) begin
            n_fail++; $display("FAIL prio_ref: got ref=%0h rd=%0h act=%0h want ref=8 only", ref_gnt, rd_gnt, act_gnt); end
        @(posedge clk); #1;
        n_checks++; if (cmd_valid !== 1'b1 || cmd_type !== REF || cmd_ba !== 2'd3) begin
            n_fail++; $display("FAIL prio_ref_cmd: got v=%0b t=%0d ba=%0d want v=1 t=5 ba=3", cmd_valid, cmd_type, cmd_ba); end
        n_checks++; if (cmd_ra !== 16'hA003 || cmd_ca !== 10'h103 || cmd_id !== 4'hB || cmd_len !== 8'h13) begin
            n_fail++; $display("FAIL prio_fields: got ra=%0h ca=%0h id=%0h len=%0h want A003 103 b 13", cmd_ra, cmd_ca, cmd_id, cmd_len); end
        ref_req = 4'h0;
        #1;
        n_checks++; if (rd_gnt !== 4'h1 || act_gnt !== 4'h0) begin n_fail++; $display("FAIL prio_rd: got rd=%0h act=%0h want rd=1 act=0", rd_gnt, act_gnt); end
        @(posedge clk); #1;
        n_checks++; if (cmd_type !== RD || cmd_ba !== 2'd0) begin n_fail++; $display("FAIL prio_rd_cmd: got t=%0d ba=%0d want t=2 ba=0", cmd_type, cmd_ba); end
        rd_req = 4'h4;
        #1;
        n_checks++; if (act_gnt !== 4'h2 || rd_gnt !== 4'h0) begin n_fail++; $display("FAIL blocked_rd_act: got act=%0h rd=%0h want act=2 rd=0", act_gnt, rd_gnt); end
        @(posedge clk); #1;
        n_checks++; if (cmd_type !== ACT || cmd_ba !== 2'd1) begin n_fail++; $display("FAIL blocked_act_cmd: got t=%0d ba=%0d want t=1 ba=1", cmd_type, cmd_ba); end
        rd_req = 4'h1; act_req = 4'h1;
        #1;
        n_checks++; if (act_gnt !== 4'h0 || rd_gnt !== 4'h0) begin n_fail++; $display("FAIL single_class: got act=%0h rd=%0h want 0 0", act_gnt, rd_gnt); end
        @(posedge clk); #1;
        n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %0b want 0", cmd_valid); end
        clear_reqs();
        t_ccd_m1 = 4'd0;
    endtask

    initial begin
        t_rrd_m1 = '0; t_ccd_m1 = '0; t_wtr_m1 = '0; t_rtw_m1 = '0; t_faw_m1 = '0;
        clear_reqs();
        for (int b = 0; b < 4; b++) begin
            ra_i[b*16 +: 16] = 16'hA000 + 16'(b);
            ca_i[b*10 +: 10] = 10'h100 + 10'(b);
            id_i[b*4 +: 4]   = 4'h8 + 4'(b);
            len_i[b*8 +: 8]  = 8'h10 + 8'(b);
        end
        test_reset();
        test_rr_fairness();
        test_trrd();
        test_tfaw();
        test_turnaround();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
